// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a fetch port and a data port onto one memory port.
// Define MEM_TIMEOUT_EN to build the BUSY watchdog that aborts stalled accesses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT must be 2..255 and STARVE_MAX 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        fetch_wins;
  logic        data_wins;
  logic        finish;
  logic [31:0] resp_data;

  // Data has priority except when fetch has been passed over STARVE_MAX times.
  assign fetch_wins = i_req && (!d_req || starve_cnt == STARVE_LIM);
  assign data_wins  = d_req && !fetch_wins;

`ifdef MEM_TIMEOUT_EN
  // The stall that would make wait_cnt reach TIMEOUT ends the access instead.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first; otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    finish    = mem_ready;
    resp_data = mem_rdata;
`ifdef MEM_TIMEOUT_EN
    if (!mem_ready && wait_cnt == WAIT_LAST) begin
      finish    = 1'b1;
      resp_data = 32'hDEAD_BEEF;
    end
`endif
  end

  // NOTE: state is updated with non-blocking assignments only, so every register in
  // this block sees the pre-edge value of every other one regardless of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt   <= '0;
      err        <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (data_wins) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (i_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else if (fetch_wins) begin
            state      <= BUSY_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= 4'b1111;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (finish) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              i_rdata <= resp_data;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= resp_data;
              d_ack   <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            err     <= !mem_ready;
`endif
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
